if_stage: RTL and testbench

//   Instruction-fetch stage and IF/ID pipeline register of the RISC-V pipeline.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch path.
package riscv_pkg;

   localparam int              XLEN             = 32;
   localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

   // One fetched instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. Used both as the fetch buffer and as
// the in-order PC tag queue for outstanding requests.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter type T     = fetch_entry_t,
   parameter int  DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  T              wdata_i,
   output T              rdata_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointer/occupancy next state; flush empties the queue and beats push/pop.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = ptr_inc(wr_q);
         if (do_pop)  rd_d = ptr_inc(rd_q);
         if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && full_o && !do_pop && !flush_i));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage plus IF/ID register. Issues in-order fetches with a
// credit limit, tags responses with their PC, buffers them, and squashes
// in-flight fetches on an EX redirect.
module if_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall_d,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            validD
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 2;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   outst_q, outst_d, disc_q, disc_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pcd_q, pcd_d, pcp4_q, pcp4_d;
   logic            vld_q, vld_d;

   logic            accept, rsp_keep, rsp_drop, buf_pop;
   logic [SW-1:0]   credit_used;
   fetch_entry_t    buf_wdata, buf_head;
   logic [CW-1:0]   buf_cnt, tag_cnt;
   logic            buf_empty, buf_full, tag_empty, tag_full;
   logic [XLEN-1:0] tag_head;

   // Every in-flight, buffered or to-be-discarded fetch holds a credit, so
   // the buffer can always absorb whatever comes back.
   assign credit_used    = SW'(outst_q) + SW'(buf_cnt) + SW'(disc_q);
   assign imem_req_valid = !redirect_valid && (credit_used < SW'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid && imem_req_ready;
   assign rsp_drop       = imem_rsp_valid && (disc_q != '0);
   assign rsp_keep       = imem_rsp_valid && (disc_q == '0);
   assign buf_pop        = !redirect_valid && !stall_d && !buf_empty;
   assign buf_wdata      = '{pc: tag_head, instr: imem_rsp_data};

   fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(DEPTH)) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .pop_i   (rsp_keep),
      .flush_i (redirect_valid),
      .wdata_i (pc_q),
      .rdata_o (tag_head),
      .count_o (tag_cnt),
      .empty_o (tag_empty),
      .full_o  (tag_full)
   );

   fetch_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_fetch_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rsp_keep),
      .pop_i   (buf_pop),
      .flush_i (redirect_valid),
      .wdata_i (buf_wdata),
      .rdata_o (buf_head),
      .count_o (buf_cnt),
      .empty_o (buf_empty),
      .full_o  (buf_full)
   );

   // Fetch PC and request bookkeeping. On redirect every outstanding fetch
   // becomes a discard, less the one (kept or dropped) returning right now.
   always_comb begin
      pc_d    = pc_q;
      outst_d = outst_q;
      disc_d  = disc_q;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         outst_d = '0;
         disc_d  = outst_q + disc_q - CW'(imem_rsp_valid);
      end else begin
         if (accept) pc_d = pc_q + XLEN'(4);
         outst_d = outst_q + CW'(accept) - CW'(rsp_keep);
         disc_d  = disc_q - CW'(rsp_drop);
      end
   end

   // IF/ID register: redirect bubbles, stall holds, otherwise take the buffer head.
   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      vld_d   = vld_q;
      if (redirect_valid) begin
         vld_d   = 1'b0;
         instr_d = NOP_INSTR;
      end else if (!stall_d) begin
         if (!buf_empty) begin
            vld_d   = 1'b1;
            instr_d = buf_head.instr;
            pcd_d   = buf_head.pc;
            pcp4_d  = buf_head.pc + XLEN'(4);
         end else begin
            vld_d   = 1'b0;
            instr_d = NOP_INSTR;
         end
      end
   end

   // Fetch-side and IF/ID state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         outst_q <= '0;
         disc_q  <= '0;
         instr_q <= NOP_INSTR;
         pcd_q   <= '0;
         pcp4_q  <= XLEN'(4);
         vld_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         pcp4_q  <= pcp4_d;
         vld_q   <= vld_d;
      end
   end

   assign InstrD   = instr_q;
   assign PCD      = pcd_q;
   assign PCPlus4D = pcp4_q;
   assign validD   = vld_q;

   a_tag_sync:  assert property (@(posedge clk) disable iff (!rst_n) tag_cnt == outst_q);
   a_tag_room:  assert property (@(posedge clk) disable iff (!rst_n) !(accept && tag_full));
   a_tag_avail: assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && tag_empty));
   a_buf_room:  assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp_keep && buf_full && !buf_pop && !redirect_valid));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a bench-side instruction memory answers one
// cycle after each accepted request; a negedge monitor checks requests and
// IF/ID output against queues of expected addresses/PCs filled by stimulus.
module tb_if_stage;
   import riscv_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall_d = 1'b0;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        validD;

   if_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_d        (stall_d),
      .InstrD         (InstrD),
      .PCD            (PCD),
      .PCPlus4D       (PCPlus4D),
      .validD         (validD)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   typedef enum int {P_NONE, P_RST, P_NOREQ, P_HOLD} probe_t;

   // stimulus-owned
   int          acc_limit = 0, n_addr = 0, n_pc = 0, tmo_cnt = 0;
   logic        rdy_block = 1'b0, rsp_hold = 1'b0;
   logic [31:0] exp_addr [256];
   logic [31:0] exp_pc   [256];
   logic [31:0] hold_addr = '0;
   probe_t      probe = P_NONE;
   // memory-owned
   int          acc_cnt = 0;
   logic [31:0] acc_log [256];
   logic [31:0] pending [$];
   // monitor-owned
   int          checks = 0, errors = 0, rd_addr = 0, rd_pc = 0, tmo_seen = 0;
   logic [31:0] prev_instr, prev_pcd, prev_pcp4;
   logic        prev_vld;
   // edge-capture
   logic        edge_stall = 1'b0, edge_redir = 1'b0;

   assign imem_req_ready = (acc_cnt < acc_limit) && !rdy_block;

   // Instruction memory model: accept at the edge, answer during the next cycle.
   always @(posedge clk) begin : imem
      logic        acc;
      logic [31:0] a;
      acc = rst_n && imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      #1;
      if (!rst_n) begin
         pending.delete();
         imem_rsp_valid = 1'b0;
      end else begin
         if (acc) begin
            acc_log[acc_cnt] = a;
            acc_cnt++;
            pending.push_back(a);
         end
         if (!rsp_hold && pending.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pending.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      edge_stall <= stall_d;
      edge_redir <= redirect_valid;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Monitor: sole owner of the check/error counters.
   always @(negedge clk) begin
      if (tmo_cnt != tmo_seen) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d wait(s) expired", tmo_cnt - tmo_seen);
         tmo_seen = tmo_cnt;
      end
      while (rd_addr < acc_cnt) begin
         if (rd_addr >= n_addr) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %h expected none", acc_log[rd_addr]);
         end else begin
            chk("req_addr", acc_log[rd_addr], exp_addr[rd_addr]);
         end
         rd_addr++;
      end
      case (probe)
         P_RST: begin
            chk("rst_validD", 32'(validD), 32'd0);
            chk("rst_InstrD", InstrD, NOP);
            chk("rst_PCD", PCD, 32'h0);
            chk("rst_PCPlus4D", PCPlus4D, 32'h4);
            chk("rst_req_addr", imem_req_addr, 32'h0);
         end
         P_NOREQ: chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
         P_HOLD: begin
            chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
            chk("hold_req_addr", imem_req_addr, hold_addr);
            chk("hold_validD", 32'(validD), 32'd0);
            chk("hold_InstrD", InstrD, NOP);
         end
         default: ;
      endcase
      if (rst_n && probe != P_RST) begin
         if (edge_redir) begin
            chk("redir_validD", 32'(validD), 32'd0);
            chk("redir_InstrD", InstrD, NOP);
         end else if (edge_stall) begin
            chk("stall_validD", 32'(validD), 32'(prev_vld));
            chk("stall_InstrD", InstrD, prev_instr);
            chk("stall_PCD", PCD, prev_pcd);
            chk("stall_PCPlus4D", PCPlus4D, prev_pcp4);
         end else if (validD) begin
            if (rd_pc >= n_pc) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr: got PCD %h expected none", PCD);
            end else begin
               chk("PCD", PCD, exp_pc[rd_pc]);
               chk("InstrD", InstrD, instr_of(exp_pc[rd_pc]));
               chk("PCPlus4D", PCPlus4D, exp_pc[rd_pc] + 32'd4);
            end
            rd_pc++;
         end else begin
            chk("idle_InstrD", InstrD, NOP);
         end
      end
      prev_vld   = validD;
      prev_instr = InstrD;
      prev_pcd   = PCD;
      prev_pcp4  = PCPlus4D;
   end

   // All stimulus changes land 2 time units after the rising edge.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Allow n more fetches from a0; 'deliver' says whether they should reach decode.
   task automatic issue(input logic [31:0] a0, input int n, input bit deliver);
      for (int i = 0; i < n; i++) begin
         exp_addr[n_addr] = a0 + 32'(4 * i);
         n_addr++;
         if (deliver) begin
            exp_pc[n_pc] = a0 + 32'(4 * i);
            n_pc++;
         end
      end
      acc_limit += n;
   endtask

   task automatic wait_acc(input int max);
      int k = 0;
      while (acc_cnt != acc_limit && k < max) begin step(); k++; end
      if (acc_cnt != acc_limit) tmo_cnt++;
   endtask

   task automatic wait_drain(input int max);
      int k = 0;
      while ((rd_pc != n_pc || acc_cnt != acc_limit) && k < max) begin step(); k++; end
      if (rd_pc != n_pc || acc_cnt != acc_limit) tmo_cnt++;
   endtask

   initial begin
      // reset values while reset is held
      #1;
      rst_n = 1'b0;
      probe = P_RST;
      step();
      probe = P_NONE;
      step();
      rst_n = 1'b1;

      // 1: streaming from RESET_PC
      issue(32'h0, 6, 1'b1);
      wait_drain(60);

      // 2: stall three cycles mid-stream; the buffer fills and requests stop
      issue(32'd24, 6, 1'b1);
      begin
         int k = 0;
         while (rd_pc < n_pc - 5 && k < 30) begin step(); k++; end
         if (rd_pc < n_pc - 5) tmo_cnt++;
      end
      stall_d = 1'b1;
      step(2);
      probe = P_NOREQ;
      step();
      probe   = P_NONE;
      stall_d = 1'b0;
      wait_drain(60);

      // 3: redirect to 0x100 with two fetches outstanding; both are squashed
      rsp_hold = 1'b1;
      issue(32'd48, 2, 1'b0);
      wait_acc(20);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      rsp_hold       = 1'b0;
      issue(32'h100, 3, 1'b1);
      wait_drain(60);

      // 4: redirect together with stall_d and a returning response
      rsp_hold = 1'b1;
      issue(32'h10C, 1, 1'b0);
      wait_acc(20);
      rsp_hold = 1'b0;
      step();
      stall_d        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      stall_d        = 1'b0;
      redirect_valid = 1'b0;
      issue(32'h200, 2, 1'b1);
      wait_drain(60);

      // 5: imem not ready for five cycles; address holds, decode idles
      rdy_block = 1'b1;
      issue(32'h208, 3, 1'b1);
      hold_addr = 32'h208;
      probe     = P_HOLD;
      step(5);
      probe     = P_NONE;
      rdy_block = 1'b0;
      wait_drain(60);

      // PC wrap: PCPlus4D and the fetch adder drop the carry
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      issue(32'hFFFF_FFFC, 2, 1'b1);
      wait_drain(60);

      // 6: async reset with responses sitting in the buffer
      stall_d = 1'b1;
      issue(32'h4, 2, 1'b0);
      wait_acc(20);
      step(2);
      #2;
      rst_n   = 1'b0;
      stall_d = 1'b0;
      probe   = P_RST;
      step();
      probe = P_NONE;
      step();
      rst_n = 1'b1;
      issue(32'h0, 3, 1'b1);
      wait_drain(60);

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute backstop so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: got no finish expected finish before 20000");
      $fatal(1, "watchdog");
   end

endmodule
